led_backward: RTL and testbench
===============================

# led_backward

Reverse-direction LED sweeper. It lights one LED of a WIDTH-wide bank, starting at the MSB and stepping toward LED0 at a programmable rate. It raises a sticky `done` on arrival. It sits beside the forward sweeper in the LED blinker top level; the sequencer chains the two via the same level-`en` / sticky-`done` protocol to produce a ping-pong pattern.

## Interface
- `WIDTH`, default 4: number of LEDs; legal range ≥2.
- `STEP`, default 1: positions moved per advance; legal range 1..WIDTH-1.
- `TICK_DIV`, default 1: clock cycles per advance; legal range ≥1 (1 = advance every cycle).
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset is asynchronous and active-high.
- `en` input 1: level enable. High = run or hold. Low = return to idle.
- `leds` output WIDTH: one-hot LED drive, always equal to `1 << pos`.
- `pos` output clog2(WIDTH): current lit index.
- `done` output 1: sticky completion flag; high while LED0 is held.
- `busy` output 1: high while sweeping (RUN state).

## Operation
- States: IDLE, RUN, DONE.
- Reset or idle values: state=IDLE, pos=WIDTH-1, leds=1<<(WIDTH-1), done=0, busy=0, divider=0.
- `rst` asserted at any time forces the idle values immediately (asynchronous), including mid-sweep.
- `en` low, any state: next edge loads the idle values (synchronous abort). This has priority over all other transitions.
- IDLE with `en`=1 at an edge: go to RUN, busy=1, divider cleared. LEDs stay at MSB.
- RUN: divider counts 0..TICK_DIV-1. The tick is `divider==TICK_DIV-1`, and the divider wraps to 0 on the tick.
- On a tick: pos_next = (pos ≤ STEP) ? 0 : pos-STEP. The comparison is done before subtraction, so there is no underflow. pos saturates at 0 and never wraps to WIDTH-1.
- When pos_next==0 on a tick, on that same edge: pos=0, leds=LED0, state=DONE, done=1, busy=0.
- DONE: outputs frozen and the divider is idle until `en` goes low.
- `done` never pulses. It drops only via `en` low or `rst`.
- `leds` and `pos` are registered together and are never inconsistent.

## Timing
- Number of advances N = ceil((WIDTH-1)/STEP).
- `done` rises N×TICK_DIV edges after the edge that entered RUN.
- WIDTH=4, STEP=1, TICK_DIV=1, en rises before edge E0:
  - E0: RUN, leds 1000.
  - E1: 0100.
  - E2: 0010.
  - E3: 0001, done=1, busy=0.
- `en` low sampled at edge Ek: idle values visible after Ek. Re-raising `en` restarts the sweep from the MSB; there is no resume.
- Simultaneous `en` fall and tick: the abort wins, and pos does not advance.
- Registered outputs only; there are no combinational paths from `en` to outputs.

## Structure
- Shared package/include `led_sweep_pkg`:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2. The forward sweeper reuses them.
  - `clog2` function for `pos` width.
- Sub-module `led_tick_div #(TICK_DIV)`:
  - Ports: clk, rst, clr, run → tick.
  - Reused by the forward sweeper once it gains a rate parameter.
- Top-level body: FSM, saturating position register, one-hot decoder.

## Test plan
- Reset defaults: WIDTH=4. Assert `rst` mid-sweep at pos=1 → leds=1000, pos=3, done=0, busy=0 immediately, without waiting for a clock edge.
- Basic sweep: WIDTH=4, STEP=1, TICK_DIV=1, `en` held high → leds 1000, 0100, 0010, 0001 on E0..E3; done=1 at E3 and held for 10 more cycles.
- Saturation: WIDTH=4, STEP=2 → pos 3, 1, 0; done after 2 ticks; pos never wraps.
- Divider: WIDTH=8, STEP=3, TICK_DIV=5 → pos 7, 4, 1, 0 with 5-cycle spacing; done at E15.
- Abort and restart: drop `en` while pos=2 → next edge shows idle values. Re-raise `en` → the sweep restarts from the MSB with a full N×TICK_DIV latency.
- Race: `en` falls on the same edge as a tick (TICK_DIV=3) → pos returns to WIDTH-1, not pos-STEP, and done stays 0.

Source files
------------

// File: rtl/led_sweep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_sweep_pkg                                                        |
// | Shared state encodings and helpers for the LED sweepers.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package led_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Ceiling log2; used for elaboration-time widths only.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_tick_div                                                         |
// | Rate divider: pulses tick once every TICK_DIV cycles while run.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_tick_div
    import led_sweep_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = run && !clr && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            if (r_cnt == c_LAST) r_cnt <= '0;
            else                 r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_backward.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_backward                                                         |
// | Lights one LED, stepping from MSB down to LED0, then holds done.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_backward
    import led_sweep_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic [WIDTH-1:0]        leds,
    output logic [clog2(WIDTH)-1:0] pos,
    output logic                    done,
    output logic                    busy
);

    localparam int PW = clog2(WIDTH);
    localparam logic [PW-1:0]    c_POS_MSB  = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    c_STEP     = PW'(STEP);
    localparam logic [WIDTH-1:0] c_LEDS_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    sweep_state_t     r_state;
    logic [PW-1:0]    r_pos;
    logic [WIDTH-1:0] r_leds;
    logic             r_done;
    logic             r_busy;

    logic             w_tick;
    logic             w_clr;
    logic [PW-1:0]    w_pos_next;
    logic [WIDTH-1:0] w_leds_next;

    // Divider only runs while sweeping; an abort clears it with the FSM.
    assign w_clr = !en || (r_state != RUN);

    led_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .run  (r_state == RUN),
        .tick (w_tick)
    );

    // Compare before subtracting so the position saturates at LED0.
    assign w_pos_next  = (r_pos <= c_STEP) ? '0 : (r_pos - c_STEP);
    assign w_leds_next = WIDTH'(1) << w_pos_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pos   <= c_POS_MSB;
            r_leds  <= c_LEDS_MSB;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (!en) begin
            r_state <= IDLE;
            r_pos   <= c_POS_MSB;
            r_leds  <= c_LEDS_MSB;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= RUN;
                    r_busy  <= 1'b1;
                end
                RUN: begin
                    if (w_tick) begin
                        r_pos  <= w_pos_next;
                        r_leds <= w_leds_next;
                        if (w_pos_next == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_pos   <= c_POS_MSB;
                    r_leds  <= c_LEDS_MSB;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign leds = r_leds;
    assign pos  = r_pos;
    assign done = r_done;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_backward.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_backward                                                      |
// | Four sweeper configurations checked against a per-edge model.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_led_backward;

    logic       clk;
    logic       rst;
    logic [3:0] en;

    logic [3:0] leds_a, leds_b, leds_d;
    logic [7:0] leds_c;
    logic [1:0] pos_a, pos_b, pos_d;
    logic [2:0] pos_c;
    logic       done_a, done_b, done_c, done_d;
    logic       busy_a, busy_b, busy_c, busy_d;

    int passed = 0;
    int total  = 0;

    // Instance parameters: A basic, B saturation, C divider, D race.
    int cw[4] = '{4, 4, 8, 4};
    int cs[4] = '{1, 2, 3, 1};
    int ct[4] = '{1, 1, 5, 3};
    // Edges seen with en high since the sweep was entered; -1 means idle.
    int m[4]  = '{-1, -1, -1, -1};

    led_backward #(.WIDTH(4), .STEP(1), .TICK_DIV(1)) u_a (
        .clk(clk), .rst(rst), .en(en[0]), .leds(leds_a), .pos(pos_a), .done(done_a), .busy(busy_a));
    led_backward #(.WIDTH(4), .STEP(2), .TICK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .en(en[1]), .leds(leds_b), .pos(pos_b), .done(done_b), .busy(busy_b));
    led_backward #(.WIDTH(8), .STEP(3), .TICK_DIV(5)) u_c (
        .clk(clk), .rst(rst), .en(en[2]), .leds(leds_c), .pos(pos_c), .done(done_c), .busy(busy_c));
    led_backward #(.WIDTH(4), .STEP(1), .TICK_DIV(3)) u_d (
        .clk(clk), .rst(rst), .en(en[3]), .leds(leds_d), .pos(pos_d), .done(done_d), .busy(busy_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || !en[i]) m[i] = -1;
            else               m[i] = m[i] + 1;
        end
    end

    function automatic int exp_pos(input int i);
        int p;
        if (m[i] < 0) return cw[i] - 1;
        p = (cw[i] - 1) - cs[i] * (m[i] / ct[i]);
        return (p < 0) ? 0 : p;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic check_model(input int i, input int p, input int l, input int d, input int b);
        int ep;
        ep = exp_pos(i);
        check($sformatf("pos[%0d]", i), p, ep);
        check($sformatf("leds[%0d]", i), l, 1 << ep);
        check($sformatf("done[%0d]", i), d, (m[i] >= 0 && ep == 0) ? 1 : 0);
        check($sformatf("busy[%0d]", i), b, (m[i] >= 0 && ep != 0) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        check_model(0, int'(pos_a), int'(leds_a), int'(done_a), int'(busy_a));
        check_model(1, int'(pos_b), int'(leds_b), int'(done_b), int'(busy_b));
        check_model(2, int'(pos_c), int'(leds_c), int'(done_c), int'(busy_c));
        check_model(3, int'(pos_d), int'(leds_d), int'(done_d), int'(busy_d));
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset leds_a", int'(leds_a), 8);
        check("reset pos_c", int'(pos_c), 7);
        check("reset busy_a", int'(busy_a), 0);
        rst = 1'b0;

        edge_step();
        en = 4'b1111;
        edge_step();                                   // E0
        check("E0 leds_a", int'(leds_a), 8);
        check("E0 busy_a", int'(busy_a), 1);
        edge_step();                                   // E1
        check("E1 leds_a", int'(leds_a), 4);
        check("E1 pos_b", int'(pos_b), 1);
        edge_step();                                   // E2
        check("E2 leds_a", int'(leds_a), 2);
        check("E2 pos_b sat", int'(pos_b), 0);
        check("E2 done_b", int'(done_b), 1);
        check("E2 pos_d", int'(pos_d), 3);
        en[3] = 1'b0;                                  // abort lands on D's first tick
        edge_step();                                   // E3
        check("E3 leds_a", int'(leds_a), 1);
        check("E3 done_a", int'(done_a), 1);
        check("E3 busy_a", int'(busy_a), 0);
        check("race pos_d", int'(pos_d), 3);
        check("race done_d", int'(done_d), 0);
        for (int k = 4; k <= 15; k++) begin
            edge_step();
            if (k == 5)  check("E5 pos_c", int'(pos_c), 4);
            if (k == 10) check("E10 pos_c", int'(pos_c), 1);
            if (k == 13) check("held done_a", int'(done_a), 1);
            if (k == 13) check("held pos_b", int'(pos_b), 0);
            if (k == 14) check("E14 done_c", int'(done_c), 0);
            if (k == 15) check("E15 pos_c", int'(pos_c), 0);
            if (k == 15) check("E15 done_c", int'(done_c), 1);
        end

        en = 4'b0000;
        edge_step();
        check("drop done_a", int'(done_a), 0);
        en[0] = 1'b1;
        edge_step();                                   // E0
        edge_step();                                   // E1
        check("abort pre pos_a", int'(pos_a), 2);
        en[0] = 1'b0;
        edge_step();
        check("abort pos_a", int'(pos_a), 3);
        check("abort leds_a", int'(leds_a), 8);
        check("abort busy_a", int'(busy_a), 0);
        en[0] = 1'b1;
        edge_step();                                   // E0
        check("restart leds_a", int'(leds_a), 8);
        edge_step();
        edge_step();                                   // E2
        check("restart E2 done_a", int'(done_a), 0);
        edge_step();                                   // E3
        check("restart E3 done_a", int'(done_a), 1);

        en[0] = 1'b0;
        edge_step();
        en[0] = 1'b1;
        edge_step();                                   // E0
        edge_step();                                   // E1
        edge_step();                                   // E2
        check("pre-rst pos_a", int'(pos_a), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async leds_a", int'(leds_a), 8);
        check("async pos_a", int'(pos_a), 3);
        check("async done_a", int'(done_a), 0);
        check("async busy_a", int'(busy_a), 0);
        #2;
        rst = 1'b0;
        repeat (6) edge_step();
        check("post-rst done_a", int'(done_a), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
